// File: rtl/sr_bank_pkg.sv
// Shared encodings for the SR flag-bank controller: command codes, FSM states
// and the illegal-command test used by both the controller and its users.
package sr_bank_pkg;

  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_RST  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_ILL  = 2'b11;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_APPLY = 1'b1
  } state_e;

  function automatic logic is_illegal(input logic [1:0] cmd);
    return cmd == SR_ILL;
  endfunction

endpackage

// File: rtl/sr_bank_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps modulo N.
// Zero latency; the caller holds req until it sees its grant take effect.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic found;
  int   pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = PW'(pos);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/sr_bank_ctrl.sv
// Round-robin controller applying set/reset/hold commands to a flag bank, one per 2 cycles.
// req sampled at E1, q/qb/ack update at E2; optional err_cnt counter under SR_BANK_ERRCNT_EN.
module sr_bank_ctrl
  import sr_bank_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int FLAGS = 8,
  parameter int AW    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [2*N_REQ-1:0]  sr,
  input  logic [AW*N_REQ-1:0] addr,
  input  logic                clr_err,
  output logic [FLAGS-1:0]    q,
  output logic [FLAGS-1:0]    qb,
  output logic [N_REQ-1:0]    ack,
  output logic                busy,
  output logic                err,
  output logic [7:0]          err_cnt
);

  localparam int PW = $clog2(N_REQ);

  state_e           state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [FLAGS-1:0] q_q, q_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             err_q, err_d;

  logic [N_REQ-1:0] req_masked;
  logic [N_REQ-1:0] arb_grant;
  logic [PW-1:0]    arb_idx;
  logic             arb_any;
  logic [1:0]       cmd_sel;
  logic [AW-1:0]    addr_sel;
  logic             illegal;

  // A requester being acked this cycle is not yet allowed to win again.
  assign req_masked = req & ~ack_q;

  rr_arbiter #(
    .N  (N_REQ),
    .PW (PW)
  ) u_arb (
    .req   (req_masked),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    cmd_sel  = '0;
    addr_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) begin
        cmd_sel  = sr[2*i +: 2];
        addr_sel = addr[AW*i +: AW];
      end
    end
  end

  assign illegal = is_illegal(cmd_q) || (int'(addr_q) >= FLAGS);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    q_d      = q_q;
    ack_d    = '0;
    err_d    = err_q;
    if (clr_err) begin
      err_d = 1'b0;
    end
    unique case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          win_d   = arb_idx;
          cmd_d   = cmd_sel;
          addr_d  = addr_sel;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        state_d  = S_IDLE;
        rr_ptr_d = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + PW'(1);
        for (int i = 0; i < N_REQ; i++) begin
          ack_d[i] = (PW'(i) == win_q);
        end
        // An illegal command beats a same-edge clr_err.
        if (illegal) begin
          err_d = 1'b1;
        end else begin
          for (int i = 0; i < FLAGS; i++) begin
            if (AW'(i) == addr_q) begin
              if (cmd_q == SR_SET) begin
                q_d[i] = 1'b1;
              end else if (cmd_q == SR_RST) begin
                q_d[i] = 1'b0;
              end
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      cmd_q    <= SR_HOLD;
      addr_q   <= '0;
      q_q      <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      q_q      <= q_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

`ifdef SR_BANK_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturates at 255; only rst clears it.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (state_q == S_APPLY && illegal && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

  assign q    = q_q;
  assign qb   = ~q_q;
  assign ack  = ack_q;
  assign busy = (state_q == S_APPLY);
  assign err  = err_q;

endmodule
